// File: rtl/img_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// img_pkg: frame geometry, sequencer state encoding and result-word layout | rev 1.0
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int PIXEL_COUNT = 76800;
  localparam int BIN_COUNT   = 256;

  localparam int RES_IDX_MSB = 31;
  localparam int RES_IDX_LSB = 24;
  localparam int RES_CNT_MSB = 23;
  localparam int RES_CNT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PUSH  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  function automatic logic [7:0] res_index(input logic [31:0] word);
    return word[RES_IDX_MSB:RES_IDX_LSB];
  endfunction

  function automatic logic [23:0] res_count(input logic [31:0] word);
    return word[RES_CNT_MSB:RES_CNT_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_frame_controller_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// handshake_watchdog: stall counter cleared on progress, flags TIMEOUT idle cycles | rev 1.0
// ---------------------------------------------------------------------------
module handshake_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic progress,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || progress || !active) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th consecutive stalled cycle so the next edge lands in ERR.
  assign expired = active && !progress && (count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/histogram_frame_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// histogram_frame_controller: frame read -> histogram push -> result collection | rev 1.0
// ---------------------------------------------------------------------------
module histogram_frame_controller #(
  parameter int PIXEL_COUNT = img_pkg::PIXEL_COUNT,
  parameter int BIN_COUNT   = img_pkg::BIN_COUNT,
  parameter int ADDR_W      = 17,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              img_rd_o,
  output logic [ADDR_W-1:0] img_addr_o,
  input  logic [7:0]        img_data_i,
  output logic              pix_valid_o,
  output logic [7:0]        pix_data_o,
  input  logic              pix_ready_i,
  output logic              core_clr_o,
  output logic              core_flush_o,
  input  logic              res_valid_i,
  input  logic [31:0]       res_data_i,
  output logic              res_ready_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_addr_o,
  output logic [31:0]       ram_data_o
);

  import img_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [8:0]        res_cnt;
  logic              ord_err;

  logic start_ok, pix_hs, res_hs, last_pix, last_res, mismatch, order_bad, wd_expired;
  logic rd_n, clr_n, valid_n, flush_n, ready_n, busy_n, done_n, err_n;
  logic [7:0] data_n;

  assign start_ok  = start_i && (state == IDLE || state == DONE || state == ERR);
  assign pix_hs    = (state == PUSH) && pix_valid_o && pix_ready_i;
  assign res_hs    = (state == FLUSH) && res_ready_o && res_valid_i;
  assign last_pix  = (pix_cnt == ADDR_W'(PIXEL_COUNT - 1));
  assign last_res  = (res_cnt == 9'(BIN_COUNT - 1));
  assign mismatch  = ({1'b0, res_index(res_data_i)} != res_cnt);
  assign order_bad = ord_err || mismatch;

  handshake_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (start_ok),
    .active   (state == PUSH || state == FLUSH),
    .progress (pix_hs || res_hs),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start_i) state_nxt = FETCH;
      // The first FETCH cycle after start is the core-clear cycle; the read follows it.
      FETCH: if (img_rd_o) state_nxt = LOAD;
      LOAD:  state_nxt = PUSH;
      PUSH: begin
        if (wd_expired)  state_nxt = ERR;
        else if (pix_hs) state_nxt = last_pix ? FLUSH : FETCH;
      end
      FLUSH: begin
        if (wd_expired)              state_nxt = ERR;
        else if (res_hs && last_res) state_nxt = order_bad ? ERR : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_n    = 1'b0;
    clr_n   = 1'b0;
    valid_n = pix_valid_o;
    data_n  = pix_data_o;
    flush_n = core_flush_o;
    ready_n = res_ready_o;
    busy_n  = busy_o;
    done_n  = done_o;
    err_n   = err_o;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          clr_n  = 1'b1;
          busy_n = 1'b1;
          done_n = 1'b0;
          err_n  = 1'b0;
        end
      end
      FETCH: rd_n = !img_rd_o;
      LOAD: begin
        data_n  = img_data_i;
        valid_n = 1'b1;
      end
      PUSH: begin
        if (wd_expired) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          err_n   = 1'b1;
        end else if (pix_hs) begin
          valid_n = 1'b0;
          flush_n = last_pix;
          ready_n = last_pix;
          rd_n    = !last_pix;
        end
      end
      FLUSH: begin
        if (wd_expired || (res_hs && last_res)) begin
          flush_n = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b0;
          err_n   = wd_expired || order_bad;
          done_n  = !(wd_expired || order_bad);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      img_rd_o     <= 1'b0;
      core_clr_o   <= 1'b0;
      pix_valid_o  <= 1'b0;
      pix_data_o   <= '0;
      core_flush_o <= 1'b0;
      res_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      img_rd_o     <= rd_n;
      core_clr_o   <= clr_n;
      pix_valid_o  <= valid_n;
      pix_data_o   <= data_n;
      core_flush_o <= flush_n;
      res_ready_o  <= ready_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      err_o        <= err_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt <= '0;
      res_cnt <= '0;
      ord_err <= 1'b0;
    end else if (start_ok) begin
      pix_cnt <= '0;
      res_cnt <= '0;
      ord_err <= 1'b0;
    end else begin
      if (pix_hs) pix_cnt <= pix_cnt + 1'b1;
      if (res_hs) begin
        res_cnt <= res_cnt + 1'b1;
        ord_err <= order_bad;
      end
    end
  end

  assign img_addr_o = pix_cnt;

  // Result RAM port is a direct pass-through of the accepted word, zero when idle.
  assign ram_we_o   = res_hs;
  assign ram_addr_o = res_hs ? res_cnt[7:0] : 8'd0;
  assign ram_data_o = res_hs ? res_data_i : 32'd0;

endmodule
`default_nettype wire
